// File: rtl/key_cache_ctrl.sv
// Tag store and control FSM for the 4-slot SM4 round-key cache.
// Optional statistics counters are built when KEY_CACHE_STATS_EN is defined.
module key_cache_ctrl #(
  parameter int TAG_WIDTH = 128
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 lookup_v_i,
  input  logic [TAG_WIDTH-1:0] lookup_tag_i,
  output logic                 lookup_ready_o,
  output logic                 resp_v_o,
  output logic [1:0]           resp_slot_o,
  output logic                 resp_hit_o,
  input  logic                 resp_ready_i,
  output logic                 fill_v_o,
  output logic [1:0]           fill_slot_o,
  output logic [TAG_WIDTH-1:0] fill_tag_o,
  input  logic                 fill_ready_i,
  input  logic                 fill_done_i,
  input  logic                 invalidate_i,
  output logic [1:0]           lru_access1_o,
  output logic                 lru_v1_o,
  output logic [1:0]           lru_access2_o,
  output logic                 lru_v2_o,
  input  logic [1:0]           lru_replace_i,
  output logic [15:0]          hit_cnt_o,
  output logic [15:0]          miss_cnt_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    FILL_REQ  = 3'd2,
    FILL_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [3:0]           valid;
  logic [TAG_WIDTH-1:0] tags [4];
  logic [TAG_WIDTH-1:0] tag_q;
  logic [1:0]           slot_q;
  logic                 hit_q;

  logic       hit;
  logic [1:0] hit_slot;
  logic [1:0] victim;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Parallel tag compare; victim prefers the lowest invalid slot over the LRU pick.
  always_comb begin
    hit      = 1'b0;
    hit_slot = 2'd0;
    victim   = lru_replace_i;
    for (int i = 0; i < 4; i++) begin
      if (valid[i] && tags[i] == tag_q) begin
        hit      = 1'b1;
        hit_slot = 2'(i);
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (!valid[i]) victim = 2'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (lookup_v_i)   state_nxt = COMPARE;
      COMPARE:   state_nxt = hit ? RESP : FILL_REQ;
      FILL_REQ:  if (fill_ready_i) state_nxt = FILL_WAIT;
      FILL_WAIT: if (fill_done_i)  state_nxt = RESP;
      RESP:      if (resp_ready_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid  <= '0;
      tag_q  <= '0;
      slot_q <= 2'd0;
      hit_q  <= 1'b0;
      for (int i = 0; i < 4; i++) tags[i] <= '0;
    end else begin
      if (state == IDLE && lookup_v_i) tag_q <= lookup_tag_i;
      if (state == COMPARE) begin
        slot_q <= hit ? hit_slot : victim;
        hit_q  <= hit;
      end
      if (invalidate_i)                           valid         <= '0;
      else if (state == FILL_REQ && fill_ready_i) valid[slot_q] <= 1'b0;
      // A completing fill overrides a simultaneous invalidate for its own slot.
      if (state == FILL_WAIT && fill_done_i) begin
        valid[slot_q] <= 1'b1;
        tags[slot_q]  <= tag_q;
      end
    end
  end

  assign lookup_ready_o = (state == IDLE);
  assign resp_v_o       = (state == RESP);
  assign resp_slot_o    = slot_q;
  assign resp_hit_o     = hit_q;
  assign fill_v_o       = (state == FILL_REQ);
  assign fill_slot_o    = slot_q;
  assign fill_tag_o     = tag_q;
  assign lru_v1_o       = (state == COMPARE) && hit;
  assign lru_access1_o  = lru_v1_o ? hit_slot : 2'd0;
  assign lru_v2_o       = (state == FILL_WAIT) && fill_done_i;
  assign lru_access2_o  = lru_v2_o ? slot_q : 2'd0;

`ifdef KEY_CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
    end else if (state == COMPARE) begin
      if (hit) hit_cnt  <= sat_inc(hit_cnt);
      else     miss_cnt <= sat_inc(miss_cnt);
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`else
  assign hit_cnt_o  = 16'd0;
  assign miss_cnt_o = 16'd0;
`endif

endmodule

// File: doc/key_cache_ctrl.md
# key_cache_ctrl

Tag-store and control FSM for the 4-slot round-key cache in front of the SM4 key-expansion unit. It accepts a cipher-key lookup and answers with the slot holding that key's round keys. On a miss it selects a victim, requests a fill from key expansion, and waits for completion. It drives both access ports of the external 4-entry LRU recorder and consumes the recorder's victim index.

## Interface
- TAG_WIDTH, 128, width of cipher-key tag
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- lookup_v_i  in  1  lookup request valid
- lookup_tag_i  in  TAG_WIDTH  cipher key to look up
- lookup_ready_o  out  1  lookup accepted when lookup_v_i & lookup_ready_o
- resp_v_o  out  1  response valid
- resp_slot_o  out  2  slot holding the requested key
- resp_hit_o  out  1  1 = hit, 0 = served after fill
- resp_ready_i  in  1  response consumed
- fill_v_o  out  1  fill request valid
- fill_slot_o  out  2  slot to fill
- fill_tag_o  out  TAG_WIDTH  key to expand
- fill_ready_i  in  1  fill request accepted
- fill_done_i  in  1  one-cycle pulse: round keys written
- invalidate_i  in  1  clear all valid bits
- lru_access1_o / lru_v1_o  out  2 / 1  LRU hit-update port
- lru_access2_o / lru_v2_o  out  2 / 1  LRU fill-update port
- lru_replace_i  in  2  LRU victim index
- hit_cnt_o, miss_cnt_o  out  16 each  statistics, see Configuration

## Operation
- State per slot: valid bit and TAG_WIDTH tag register.
- FSM states and transitions:
  - IDLE: accepts a lookup and goes to COMPARE.
  - COMPARE: goes to RESP on a hit, or to FILL_REQ on a miss.
  - FILL_REQ: goes to FILL_WAIT on fill_ready_i.
  - FILL_WAIT: goes to RESP on fill_done_i.
  - RESP: goes to IDLE on resp_ready_i.
- lookup_ready_o = (state == IDLE). An accepted tag is registered and held stable until return to IDLE.
- COMPARE: all four valid slots are compared in parallel. At most one match is possible.
  - Hit: lru_v1_o = 1 with lru_access1_o = matching slot for exactly this cycle. The slot is registered and resp_hit_o = 1.
  - Miss: victim = lowest-index invalid slot if any, else lru_replace_i sampled this cycle. The victim is registered and resp_hit_o = 0.
- FILL_REQ: fill_v_o = 1 with fill_slot_o = victim and fill_tag_o = registered tag, held until fill_ready_i.
  - On acceptance the victim's valid bit is cleared.
- FILL_WAIT: on fill_done_i the tag is written, valid is set, and lru_v2_o = 1 with lru_access2_o = victim for that cycle.
  - fill_done_i outside FILL_WAIT is ignored.
- lru_v1_o and lru_v2_o are never high in the same cycle.
- RESP: resp_v_o = 1 with resp_slot_o and resp_hit_o stable until resp_ready_i.
- invalidate_i clears all valid bits in any state.
  - If it coincides with fill_done_i, the fill's valid-set wins for the victim slot.
  - If it coincides with a lookup accept in IDLE, the lookup is accepted and COMPARE sees all entries invalid.
- Reset clears valid bits and tags, returns the FSM to IDLE, and abandons any in-flight fill or response.

## Timing
- Reset values: lookup_ready_o = 1. All other outputs are 0: resp_v_o, resp_slot_o, resp_hit_o, fill_v_o, fill_slot_o, fill_tag_o, lru_v1_o, lru_v2_o, lru_access1_o, lru_access2_o, counters.
- Hit: with accept at edge N, COMPARE runs during cycle N+1 and resp_v_o rises after edge N+1. Latency is 2 cycles.
- Miss: fill_v_o rises after edge N+1. Response comes 1 cycle after the fill_done_i edge.
- The 2-bit slot index wraps naturally; no arithmetic on it.
- The FSM, valid bits, and all registered outputs are asynchronously cleared. lru_v*/lru_access* are combinational from state and compare result.

## Configuration
- KEY_CACHE_STATS_EN defined: hit_cnt_o/miss_cnt_o count COMPARE hits/misses.
  - Counters are 16-bit and saturate at 0xFFFF.
  - They clear on reset but not on invalidate_i.
- KEY_CACHE_STATS_EN undefined: no counter registers; both ports tied to 0.

## Test plan
- Reset, then lookup key A on an empty cache -> miss, fill_slot_o=0, fill_tag_o=A. After fill_done_i: resp_slot_o=0, resp_hit_o=0, lru_v2_o pulse with access 0.
- Fill keys A,B,C,D, then look up B -> resp_hit_o=1, resp_slot_o=1, 2-cycle latency, lru_v1_o pulse with access1=1, no fill_v_o.
- Full cache with lru_replace_i=2, lookup key E -> fill_slot_o=2. A later lookup of C misses; a lookup of E hits slot 2.
- Hold fill_ready_i=0 for 5 cycles -> fill_v_o, fill_slot_o, fill_tag_o stable; lookup_ready_o=0 throughout. Hold resp_ready_i=0 -> resp_v_o held.
- invalidate_i in the same cycle as fill_done_i for slot 3 -> only slot 3 valid afterwards; next lookup of its key hits slot 3.
- Assert reset_i during FILL_WAIT -> fill_v_o=0, lookup_ready_o=1, all slots invalid. With KEY_CACHE_STATS_EN, hit_cnt_o and miss_cnt_o read 0; after 3 hits and 2 misses they read 3 and 2.
